lamp_sequencer: RTL and testbench
=================================

Name: lamp_sequencer

Overview:
Pattern controller for the 16-lamp colour ring. Lamp index 0 is top-left-centre; indices run clockwise to 15.
The block accepts a start command carrying a mode, speed and repeat count, then drives the ring through the selected pattern with its own prescaler. It signals completion with a one-cycle done pulse.
It sits between the panel control logic and the lamp drivers, and replaces free-running counter/decoder operation with commanded sequences.

Parameters:
N_LAMP, 16, number of lamps. Fixed at 16; pattern widths derive from it.
DIV_W, 4, prescaler and speed width.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
start  input  1  command strobe, sampled only in IDLE
stop  input  1  abort request
mode  input  2  0=CW chase, 1=CCW chase, 2=fill, 3=flash
speed  input  4  prescaler load value; each pattern step lasts 16-speed clocks
reps  input  4  number of extra pattern cycles; total cycles = reps+1
lamp_ctl  output  16  registered lamp drive, bit i = lamp i
busy  output  1  high while a sequence runs
done  output  1  one-clock pulse on normal completion

Behaviour:
- Reset (reset=0 at a clk edge) has highest priority. It forces state=IDLE, lamp_ctl=16'h0000, busy=0, done=0, div_cnt=0, pos=0, rep_cnt=0.
- It also clears any sequence in progress; no done pulse is produced.
- States:
  - IDLE: lamp_ctl=0, busy=0.
  - RUN: pattern active.
- All outputs are registered. done defaults to 0 every clock unless set as described below.
- IDLE, start=1 and stop=0 at an edge:
  - latch mode, speed and reps into mode_q, spd_q, rep_cnt
  - div_cnt<=speed, pos<=initial position, state<=RUN, busy<=1
  - lamp_ctl<=first pattern in the same edge (zero extra latency)
- IDLE, start=1 and stop=1: stop wins; the block stays IDLE.
- Initial position: mode 0 pos=0; mode 1 pos=15; mode 2 pos=0; mode 3 phase=on.
- Patterns:
  - Mode 0 and mode 1: lamp_ctl = one-hot(pos).
  - Mode 2: thermometer; bits 0..pos set.
  - Mode 3: phase on gives 16'hFFFF, phase off gives 16'h0000.
- Prescaler in RUN:
  - If div_cnt==4'hF, a tick occurs and div_cnt<=spd_q.
  - Otherwise div_cnt<=div_cnt+1.
  - speed=15 gives one step per clock; speed=0 gives 16 clocks per step.
  - The speed input is ignored after start.
- On a tick that is not on the last step of a cycle, the pattern advances:
  - Mode 0: pos+1.
  - Mode 1: pos-1.
  - Mode 2: pos+1.
  - Mode 3: phase toggles.
  - lamp_ctl updates in the same edge.
- Last step of a cycle: pos=15 for mode 0, pos=0 for mode 1, pos=15 for mode 2, phase=off for mode 3.
  - On a tick at the last step with rep_cnt!=0: rep_cnt-1, then pos/phase reload to the initial value and lamp_ctl shows the first pattern.
  - On a tick at the last step with rep_cnt==0: state<=IDLE, lamp_ctl<=0, busy<=0, done<=1 for exactly one clock.
- stop=1 in RUN: at the next edge go to IDLE with lamp_ctl<=0 and busy<=0. done stays 0. stop has priority over a coincident tick or completion.
- start in RUN is ignored; mode, reps and speed changes have no effect mid-run.
- A new start is accepted in the same clock that done is high, because the state is already IDLE.
- Arithmetic: all counters are 4-bit unsigned. pos never wraps inside a cycle because the last-step detection precedes the increment or decrement.

Test Plan:
- Reset then CW chase:
  - Stimulus: reset low 3 clk, release; start pulse with mode=0, speed=14, reps=0.
  - Response: lamp_ctl=0001 at start edge, 0002 two clocks later, …, 8000 at edge 30.
  - Response: at edge 32 lamp_ctl=0000, done=1 for one clock; busy high for edges 0–31.
- CCW chase with repeats:
  - Stimulus: mode=1, speed=15, reps=1.
  - Response: 8000,4000,…,0001,8000,…,0001 (32 clocks), then done; exactly one done pulse.
- Fill:
  - Stimulus: mode=2, speed=15, reps=0.
  - Response: 0001,0003,0007,…,FFFF on consecutive clocks, then 0000 with done.
- Flash, slowest speed:
  - Stimulus: mode=3, speed=0, reps=2.
  - Response: FFFF/0000 alternating, each held 16 clocks, 6 steps total (96 clocks), then done.
- Stop with coincident events:
  - Stimulus: stop during a mode-0 run at pos=5, coincident with a tick.
  - Response: lamp_ctl=0000 and busy=0 next edge, no done.
  - Stimulus: start and stop together in IDLE.
  - Response: stays IDLE.
- Reset mid-run and ignored start:
  - Stimulus: reset=0 in mid-run.
  - Response: all outputs 0 at that edge; no done pulse.
  - Stimulus: start pulsed while busy.
  - Response: sequence unaffected.

Source files
------------

// File: rtl/lamp_sequencer.sv
// Commanded pattern controller for the 16-lamp ring: chase CW/CCW, fill and flash
// with a per-run prescaler, repeat count and a one-clock completion pulse.
module lamp_sequencer #(
    parameter int N_LAMP = 16,
    parameter int DIV_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  speed,
    input  logic [3:0]        reps,
    output logic [N_LAMP-1:0] lamp_ctl,
    output logic              busy,
    output logic              done
);

    localparam int POS_W = $clog2(N_LAMP);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LAMP - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state, state_n;
    logic [1:0]         mode_q, mode_n;
    logic [DIV_W-1:0]   spd_q, spd_n;
    logic [3:0]         rep_cnt, rep_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic [POS_W-1:0]   pos, pos_n;
    logic               phase, phase_n;
    logic [N_LAMP-1:0]  lamp_n;
    logic               busy_n, done_n;
    logic               last_step;

    function automatic logic [N_LAMP-1:0] pattern(input logic [1:0] m,
                                                   input logic [POS_W-1:0] p,
                                                   input logic ph);
        logic [N_LAMP-1:0] v;
        v = '0;
        case (m)
            2'd0, 2'd1: v[p] = 1'b1;
            2'd2: begin
                for (int unsigned i = 0; i < N_LAMP; i++) begin
                    if (i <= 32'(p)) v[i] = 1'b1;
                end
            end
            default: v = ph ? '1 : '0;
        endcase
        return v;
    endfunction

    function automatic logic [POS_W-1:0] init_pos(input logic [1:0] m);
        return (m == 2'd1) ? POS_LAST : '0;
    endfunction

    always_comb begin
        case (mode_q)
            2'd0, 2'd2: last_step = (pos == POS_LAST);
            2'd1:       last_step = (pos == '0);
            default:    last_step = ~phase;
        endcase
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        spd_n   = spd_q;
        rep_n   = rep_cnt;
        div_n   = div_cnt;
        pos_n   = pos;
        phase_n = phase;
        lamp_n  = lamp_ctl;
        busy_n  = busy;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                lamp_n = '0;
                busy_n = 1'b0;
                if (start && !stop) begin
                    mode_n  = mode;
                    spd_n   = speed;
                    rep_n   = reps;
                    div_n   = speed;
                    pos_n   = init_pos(mode);
                    phase_n = 1'b1;
                    lamp_n  = pattern(mode, init_pos(mode), 1'b1);
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    lamp_n  = '0;
                    busy_n  = 1'b0;
                end else if (div_cnt == '1) begin
                    div_n = spd_q;
                    // Last-step check comes before the pos update, so pos never wraps.
                    if (last_step) begin
                        if (rep_cnt != 4'd0) begin
                            rep_n   = rep_cnt - 4'd1;
                            pos_n   = init_pos(mode_q);
                            phase_n = 1'b1;
                            lamp_n  = pattern(mode_q, init_pos(mode_q), 1'b1);
                        end else begin
                            state_n = IDLE;
                            lamp_n  = '0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        case (mode_q)
                            2'd1:    pos_n = pos - 1'b1;
                            2'd3:    phase_n = ~phase;
                            default: pos_n = pos + 1'b1;
                        endcase
                        lamp_n = pattern(mode_q, pos_n, phase_n);
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            mode_q   <= '0;
            spd_q    <= '0;
            rep_cnt  <= '0;
            div_cnt  <= '0;
            pos      <= '0;
            phase    <= 1'b0;
            lamp_ctl <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            mode_q   <= mode_n;
            spd_q    <= spd_n;
            rep_cnt  <= rep_n;
            div_cnt  <= div_n;
            pos      <= pos_n;
            phase    <= phase_n;
            lamp_ctl <= lamp_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed bench for lamp_sequencer: expected {lamp_ctl,busy,done} per clock is
// queued from the pattern description and compared #1 after each rising edge.
module tb_lamp_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [3:0]  speed;
    logic [3:0]  reps;
    logic [15:0] lamp_ctl;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];

    lamp_sequencer #(.N_LAMP(16), .DIV_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .mode(mode), .speed(speed), .reps(reps),
        .lamp_ctl(lamp_ctl), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_pat(input int m, input int k);
        logic [31:0] t;
        case (m)
            0: t = 32'h1 << k;
            1: t = 32'h8000 >> k;
            2: t = (32'h2 << k) - 32'h1;
            default: t = (k == 0) ? 32'hFFFF : 32'h0;
        endcase
        return t[15:0];
    endfunction

    // Push one expectation, let one edge happen, then pop and compare.
    task automatic expect_cyc(input logic [15:0] l, input logic b, input logic d,
                              input string tag);
        logic [17:0] e;
        logic [17:0] o;
        exp_q.push_back({l, b, d});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        o = {lamp_ctl, busy, done};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: lamp/busy/done got %h/%b/%b expected %h/%b/%b",
                   tag, o[17:2], o[1], o[0], e[17:2], e[1], e[0]);
        end
    endtask

    // abort_kind: 0 none, 1 stop, 2 reset; abort_at = cycles completed before abort.
    // poke_at: cycle index at which a stray start is driven while busy.
    task automatic run(input int m, input int s, input int r,
                       input int abort_kind, input int abort_at, input int poke_at);
        int steps;
        int hold;
        int n;
        steps = (m == 3) ? 2 : 16;
        hold  = 16 - s;
        n     = 0;
        start = 1'b1;
        mode  = 2'(m);
        speed = 4'(s);
        reps  = 4'(r);
        for (int c = 0; c <= r; c++) begin
            for (int k = 0; k < steps; k++) begin
                for (int h = 0; h < hold; h++) begin
                    if (abort_kind != 0 && n == abort_at) begin
                        start = 1'b0;
                        if (abort_kind == 1) begin
                            stop = 1'b1;
                            expect_cyc(16'h0000, 1'b0, 1'b0, "stop_abort");
                            stop = 1'b0;
                        end else begin
                            reset = 1'b0;
                            expect_cyc(16'h0000, 1'b0, 1'b0, "reset_abort");
                            reset = 1'b1;
                        end
                        expect_cyc(16'h0000, 1'b0, 1'b0, "after_abort");
                        return;
                    end
                    expect_cyc(exp_pat(m, k), 1'b1, 1'b0, $sformatf("m%0d_c%0d_k%0d", m, c, k));
                    n++;
                    start = (n == poke_at);
                    mode  = 2'($urandom_range(0, 3));
                    speed = 4'($urandom_range(0, 15));
                    reps  = 4'($urandom_range(0, 15));
                end
            end
        end
        start = 1'b0;
        expect_cyc(16'h0000, 1'b0, 1'b1, "done_pulse");
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = '0;
        speed = '0;
        reps  = '0;
        for (int i = 0; i < 3; i++) expect_cyc(16'h0000, 1'b0, 1'b0, "reset_hold");
        reset = 1'b1;
        expect_cyc(16'h0000, 1'b0, 1'b0, "idle_after_reset");

        run(0, 14, 0, 0, 0, -1);
        expect_cyc(16'h0000, 1'b0, 1'b0, "idle_after_cw");

        run(1, 15, 1, 0, 0, -1);
        expect_cyc(16'h0000, 1'b0, 1'b0, "idle_after_ccw");

        // Fill started again in the very clock its done pulse is visible.
        run(2, 15, 0, 0, 0, -1);
        run(2, 15, 0, 0, 0, -1);
        expect_cyc(16'h0000, 1'b0, 1'b0, "idle_after_fill");

        run(3, 0, 2, 0, 0, -1);
        expect_cyc(16'h0000, 1'b0, 1'b0, "idle_after_flash");

        // Stop sampled at edge 12: pos=5 with div_cnt==F (tick pending).
        run(0, 14, 0, 1, 12, -1);

        start = 1'b1;
        stop  = 1'b1;
        mode  = 2'd0;
        speed = 4'd15;
        expect_cyc(16'h0000, 1'b0, 1'b0, "start_stop_idle");
        start = 1'b0;
        stop  = 1'b0;
        expect_cyc(16'h0000, 1'b0, 1'b0, "start_stop_idle2");

        run(2, 12, 1, 2, 37, -1);

        run(1, 13, 0, 0, 0, 7);
        expect_cyc(16'h0000, 1'b0, 1'b0, "idle_after_poke");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
